// File: rtl/iob_diff_nth_if.sv
// Streaming bus for iob_diff_nth: input sample vectors in, difference vectors out.
// The slave modport is the engine side; the master modport is the upstream/downstream side.
interface iob_diff_nth_if #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 1
);
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*DATA_W-1:0]   in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS*DATA_W-1:0]   out_data;
    logic [CHANNELS-1:0]          out_sat;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/iob_diff_nth.sv
// Multi-channel N-th order difference engine with one output register,
// warm-up suppression after reset/clr and optional signed saturation.
module iob_diff_nth #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 1,
    parameter int ORDER    = 1,
    parameter int SATURATE = 0,
    parameter int WARMUP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    iob_diff_nth_if.slave    bus
);
    // One extra bit of headroom over the worst-case d^ORDER range keeps every stage exact.
    localparam int WF = DATA_W + ORDER + 1;
    typedef logic signed [WF-1:0] wide_t;
    localparam wide_t       SMAX = wide_t'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam wide_t       SMIN = -SMAX - wide_t'(1);
    localparam logic [2:0]  ORD3 = 3'(ORDER);

    logic                             r_vld;
    logic [CHANNELS-1:0][DATA_W-1:0]  r_data;
    logic [CHANNELS-1:0]              r_sat;
    logic [2:0]                       r_cnt;

    logic                             w_acc;
    logic                             w_sup;
    logic [2:0]                       w_cnt;
    logic [CHANNELS-1:0][DATA_W-1:0]  w_out;
    logic [CHANNELS-1:0]              w_sat;

    assign bus.in_ready  = !r_vld || bus.out_ready;
    assign bus.out_valid = r_vld;
    assign bus.out_data  = r_data;
    assign bus.out_sat   = r_sat;

    assign w_acc = bus.in_valid && bus.in_ready;
    // clr in the same cycle as an accept makes that sample see an empty history.
    assign w_cnt = clr ? 3'd0 : r_cnt;
    assign w_sup = (WARMUP != 0) && (w_cnt < ORD3);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        wide_t r_h   [ORDER];
        wide_t w_tap [ORDER];
        wide_t w_res;
        logic  w_hi;
        logic  w_lo;

        always_comb begin
            wide_t acc;
            acc = wide_t'($signed(bus.in_data[c*DATA_W +: DATA_W]));
            for (int k = 0; k < ORDER; k++) begin
                w_tap[k] = acc;
                acc      = acc - (clr ? wide_t'(0) : r_h[k]);
            end
            w_res = acc;
        end

        assign w_hi = (SATURATE != 0) && (w_res > SMAX);
        assign w_lo = (SATURATE != 0) && (w_res < SMIN);
        assign w_sat[c] = w_hi || w_lo;
        assign w_out[c] = w_hi ? SMAX[DATA_W-1:0] :
                          w_lo ? SMIN[DATA_W-1:0] : w_res[DATA_W-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < ORDER; k++) r_h[k] <= '0;
            end else if (w_acc) begin
                for (int k = 0; k < ORDER; k++) r_h[k] <= w_tap[k];
            end else if (clr) begin
                for (int k = 0; k < ORDER; k++) r_h[k] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_sat  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_acc) begin
                r_vld <= !w_sup;
                if (!w_sup) begin
                    r_data <= w_out;
                    r_sat  <= w_sat;
                end
            end else if (bus.out_ready) begin
                r_vld <= 1'b0;
            end

            if (w_acc)
                r_cnt <= (w_cnt == ORD3) ? ORD3 : w_cnt + 3'd1;
            else if (clr)
                r_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_iob_diff_nth.sv
// Bench for iob_diff_nth: directed steps plus random traffic against a
// binomial-sum model of the N-th difference over the last ORDER+1 samples.
module tb_iob_diff_nth;
    localparam int DW  = 8;
    localparam int NCH = 4;
    localparam int ORD = 2;
    localparam int SAT = 1;
    localparam int WU  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    iob_diff_nth_if #(.DATA_W(DW), .CHANNELS(NCH)) bus ();

    iob_diff_nth #(.DATA_W(DW), .CHANNELS(NCH), .ORDER(ORD), .SATURATE(SAT), .WARMUP(WU))
        dut (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));

    int nchk = 0;
    int nfail = 0;

    // Model state: sliding window of samples since reset/clr (missing = 0).
    int                 win [NCH][ORD+1];
    int                 m_cnt;
    logic               m_vld;
    logic [NCH*DW-1:0]  m_data;
    logic [NCH-1:0]     m_sat;
    int                 n_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j <= ORD; j++) win[c][j] = 0;
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [NCH*DW-1:0] d);
        int s;
        logic [DW-1:0] b;
        for (int c = 0; c < NCH; c++) begin
            for (int j = ORD; j > 0; j--) win[c][j] = win[c][j-1];
            b = d[c*DW +: DW];
            win[c][0] = int'($signed(b));
            s = 0;
            for (int j = 0; j <= ORD; j++)
                s += ((j % 2) ? -1 : 1) * binom(ORD, j) * win[c][j];
            m_sat[c] = 1'b0;
            if (SAT != 0 && s > (2**(DW-1)) - 1) begin s = (2**(DW-1)) - 1; m_sat[c] = 1'b1; end
            if (SAT != 0 && s < -(2**(DW-1)))    begin s = -(2**(DW-1));     m_sat[c] = 1'b1; end
            m_data[c*DW +: DW] = s[DW-1:0];
        end
        m_vld = !(WU != 0 && m_cnt < ORD);
        if (m_cnt < ORD) m_cnt++;
    endtask

    task automatic cyc(input logic v, input logic [NCH*DW-1:0] d, input logic ordy, input logic c);
        logic acc;
        @(negedge clk);
        bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy; clr = c;
        #1;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (!m_vld || ordy)});
        acc = v && (!m_vld || ordy);
        if (c) model_clear();
        if (acc) begin
            logic [NCH*DW-1:0] keep_d;
            logic [NCH-1:0]    keep_s;
            keep_d = m_data; keep_s = m_sat;
            model_accept(d);
            if (!m_vld) begin m_data = keep_d; m_sat = keep_s; end
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        @(posedge clk); #1;
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_vld});
        if (bus.out_valid) n_out++;
        if (m_vld) begin
            chk("out_data", {32'd0, bus.out_data}, {32'd0, m_data});
            chk("out_sat", {60'd0, bus.out_sat}, {60'd0, m_sat});
        end
    endtask

    function automatic logic [NCH*DW-1:0] rep(input logic [DW-1:0] x);
        return {NCH{x}};
    endfunction

    initial begin
        logic [NCH*DW-1:0] held;
        int guard;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        m_vld = 1'b0; m_data = '0; m_sat = '0; n_out = 0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data",  {32'd0, bus.out_data}, 64'd0);
        chk("rst_out_sat",   {60'd0, bus.out_sat}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk); rst_n = 1'b1;

        // Squares stream: second difference is 2 after warm-up, exactly 3 outputs
        n_out = 0;
        cyc(1, rep(8'd1), 1, 0);  cyc(1, rep(8'd4), 1, 0);  cyc(1, rep(8'd9), 1, 0);
        cyc(1, rep(8'd16), 1, 0); cyc(1, rep(8'd25), 1, 0); cyc(0, '0, 1, 0);
        chk("squares_count", 64'(n_out), 64'd3);

        // Saturation both directions, alternating +/-100
        cyc(0, '0, 1, 1);
        cyc(1, rep(8'd100), 1, 0); cyc(1, rep(8'h9c), 1, 0);
        cyc(1, rep(8'd100), 1, 0); cyc(1, rep(8'h9c), 1, 0);

        // Per-channel patterns: ramp, constant, step, alternating 0/255
        for (int i = 0; i < 6; i++)
            cyc(1, {((i % 2) ? 8'hff : 8'h00), (i < 3 ? 8'h00 : 8'hff), 8'd7, 8'(i)}, 1, 0);

        // Hold: back-pressure for 3 cycles with in_valid high, output must not move
        held = bus.out_data;
        repeat (3) begin
            cyc(1, 32'hdeadbeef, 0, 0);
            chk("hold_data", {32'd0, bus.out_data}, {32'd0, held});
        end
        cyc(1, 32'h01020304, 1, 0); cyc(1, 32'h05060708, 1, 0); cyc(0, '0, 1, 0);

        // clr together with accept while an output is pending
        cyc(1, 32'h11111111, 1, 0); cyc(1, 32'h22222222, 0, 0);
        cyc(1, 32'h0a0a0a0a, 1, 1);
        cyc(1, 32'h03030303, 1, 0); cyc(1, 32'h05050505, 1, 0); cyc(0, '0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(3) != 0), $urandom, ($urandom_range(9) < 7), ($urandom_range(31) == 0));

        // Async reset with a pending output
        guard = 0;
        while (!m_vld && guard < 20) begin cyc(1, $urandom, 0, 0); guard++; end
        chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        @(negedge clk); bus.in_valid = 1'b0; #2; rst_n = 1'b0; #1;
        chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_data",  {32'd0, bus.out_data}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        model_clear(); m_vld = 1'b0; m_data = '0; m_sat = '0;
        n_out = 0;
        cyc(1, $urandom, 1, 0); cyc(1, $urandom, 1, 0);
        chk("warmup_after_rst", 64'(n_out), 64'd0);
        for (int i = 0; i < 100; i++)
            cyc(($urandom_range(3) != 0), $urandom, ($urandom_range(9) < 8), 1'b0);

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

    initial begin
        #200000;
        nfail++;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
